// File: rtl/psum_accum_ctrl_gen.sv
// rtl/psum_accum_ctrl_gen.sv - partial-sum read-modify-write accumulator controller
// Walks group/pass/index counters, shadows in-flight reads for MEM_DELAY cycles, then writes psum or rdat+psum.
module psum_accum_ctrl_gen #(
  parameter int BIT_WIDTH  = 8,
  parameter int NUM_KERNEL = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DELAY  = 2,
  parameter int REG_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [REG_WIDTH-1:0]             i_conf_seglen,
  input  logic [REG_WIDTH-1:0]             i_conf_npass,
  input  logic [REG_WIDTH-1:0]             i_conf_ngroup,
  input  logic [ADDR_WIDTH-1:0]            i_conf_stride,
  input  logic                             i_conf_sat,
  input  logic                             i_psum_vld,
  input  logic [NUM_KERNEL*BIT_WIDTH-1:0]  i_psum_dat,
  output logic [ADDR_WIDTH-1:0]            o_mem_radd,
  output logic                             o_mem_rden,
  input  logic [NUM_KERNEL*BIT_WIDTH-1:0]  i_mem_rdat,
  input  logic                             i_mem_rvld,
  output logic [ADDR_WIDTH-1:0]            o_mem_wadd,
  output logic                             o_mem_wren,
  output logic [NUM_KERNEL*BIT_WIDTH-1:0]  o_mem_wdat,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_ovf,
  output logic                             o_err
);

  localparam int DW = NUM_KERNEL * BIT_WIDTH;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [REG_WIDTH-1:0]  seglen_q, npass_q, ngroup_q;
  logic [REG_WIDTH-1:0]  idx_q, idx_d, pass_q, pass_d, group_q, group_d;
  logic [ADDR_WIDTH-1:0] stride_q, base_q, base_d;
  logic                  sat_q;

  // Shadow pipeline: wr = entry still owes a write, rd = entry issued a read (kept even when squashed).
  logic [MEM_DELAY:1]    p_wr_q, p_rd_q, p_first_q;
  logic [ADDR_WIDTH-1:0] p_addr_q [1:MEM_DELAY];
  logic [DW-1:0]         p_psum_q [1:MEM_DELAY];

  logic                  wren_q, ovf_q, err_q;
  logic [ADDR_WIDTH-1:0] wadd_q;
  logic [DW-1:0]         wdat_q;

  logic                  cfg_ok, start_ok, start_bad, accept, rd_issue;
  logic                  last_idx, last_pass, last_group;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  head_wr, head_rd, head_first, do_write, err_evt, ovf_evt;
  logic [DW-1:0]         sum_w;
  logic                  ovf_any;
  logic [BIT_WIDTH-1:0]  lane_a, lane_b, lane_s;
  logic                  lane_o;

  assign cfg_ok     = i_conf_seglen >= REG_WIDTH'(MEM_DELAY + 1);
  assign start_ok   = i_start & cfg_ok;
  assign start_bad  = i_start & ~cfg_ok;
  assign accept     = i_psum_vld & (state_q == S_ACCUM) & ~start_ok;
  assign rd_issue   = accept & (pass_q != '0);
  assign addr       = base_q + ADDR_WIDTH'(idx_q);
  assign last_idx   = idx_q == seglen_q;
  assign last_pass  = pass_q == npass_q;
  assign last_group = group_q == ngroup_q;

  assign o_mem_rden = rd_issue;
  assign o_mem_radd = addr;
  assign o_mem_wren = wren_q;
  assign o_mem_wadd = wadd_q;
  assign o_mem_wdat = wdat_q;
  assign o_busy     = (state_q == S_ACCUM) | (state_q == S_DRAIN);
  assign o_done     = state_q == S_DONE;
  assign o_ovf      = ovf_q;
  assign o_err      = err_q;

  assign head_wr    = p_wr_q[MEM_DELAY];
  assign head_rd    = p_rd_q[MEM_DELAY];
  assign head_first = p_first_q[MEM_DELAY];
  assign do_write   = head_wr & (head_first | i_mem_rvld) & ~start_ok;
  assign err_evt    = (head_rd ^ i_mem_rvld) | start_bad;
  assign ovf_evt    = head_wr & ~head_first & i_mem_rvld & ovf_any & ~start_ok;

  always_comb begin
    sum_w   = '0;
    ovf_any = 1'b0;
    lane_a  = '0;
    lane_b  = '0;
    lane_s  = '0;
    lane_o  = 1'b0;
    for (int k = 0; k < NUM_KERNEL; k++) begin
      lane_a = i_mem_rdat[k*BIT_WIDTH +: BIT_WIDTH];
      lane_b = p_psum_q[MEM_DELAY][k*BIT_WIDTH +: BIT_WIDTH];
      lane_s = lane_a + lane_b;
      lane_o = (lane_a[BIT_WIDTH-1] == lane_b[BIT_WIDTH-1]) && (lane_s[BIT_WIDTH-1] != lane_a[BIT_WIDTH-1]);
      if (lane_o) begin
        ovf_any = 1'b1;
        if (sat_q) lane_s = lane_a[BIT_WIDTH-1] ? {1'b1, {(BIT_WIDTH-1){1'b0}}} : {1'b0, {(BIT_WIDTH-1){1'b1}}};
      end
      sum_w[k*BIT_WIDTH +: BIT_WIDTH] = lane_s;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    group_d = group_q;
    base_d  = base_q;
    if (start_ok) begin
      state_d = S_ACCUM;
      idx_d   = '0;
      pass_d  = '0;
      group_d = '0;
      base_d  = '0;
    end else begin
      if (accept) begin
        if (last_idx) begin
          idx_d = '0;
          if (last_pass) begin
            pass_d  = '0;
            group_d = group_q + 1'b1;
            base_d  = base_q + stride_q;
            if (last_group) state_d = S_DRAIN;
          end else begin
            pass_d = pass_q + 1'b1;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      if ((state_q == S_DRAIN) && (p_wr_q == '0) && (p_rd_q == '0)) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      pass_q   <= '0;
      group_q  <= '0;
      base_q   <= '0;
      seglen_q <= '0;
      npass_q  <= '0;
      ngroup_q <= '0;
      stride_q <= '0;
      sat_q    <= 1'b0;
      wren_q   <= 1'b0;
      wadd_q   <= '0;
      wdat_q   <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      group_q <= group_d;
      base_q  <= base_d;
      if (start_ok) begin
        seglen_q <= i_conf_seglen;
        npass_q  <= i_conf_npass;
        ngroup_q <= i_conf_ngroup;
        stride_q <= i_conf_stride;
        sat_q    <= i_conf_sat;
      end
      wren_q <= do_write;
      wadd_q <= p_addr_q[MEM_DELAY];
      wdat_q <= head_first ? p_psum_q[MEM_DELAY] : sum_w;
      ovf_q  <= ovf_q | ovf_evt;
      err_q  <= err_q | err_evt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_wr_q    <= '0;
      p_rd_q    <= '0;
      p_first_q <= '0;
      for (int s = 1; s <= MEM_DELAY; s++) begin
        p_addr_q[s] <= '0;
        p_psum_q[s] <= '0;
      end
    end else begin
      for (int s = MEM_DELAY; s >= 2; s--) begin
        p_wr_q[s]    <= p_wr_q[s-1] & ~start_ok;
        p_rd_q[s]    <= p_rd_q[s-1];
        p_first_q[s] <= p_first_q[s-1];
        p_addr_q[s]  <= p_addr_q[s-1];
        p_psum_q[s]  <= p_psum_q[s-1];
      end
      p_wr_q[1]    <= accept;
      p_rd_q[1]    <= rd_issue;
      p_first_q[1] <= pass_q == '0;
      p_addr_q[1]  <= addr;
      p_psum_q[1]  <= i_psum_dat;
    end
  end

endmodule

// File: tb/tb_psum_accum_ctrl_gen.sv
// tb/tb_psum_accum_ctrl_gen.sv - directed and randomized checks of psum_accum_ctrl_gen
// The reference computes each expected write with integer lane arithmetic over a shadow memory.
module tb_psum_accum_ctrl_gen;
  localparam int BW = 8;
  localparam int NK = 4;
  localparam int AW = 16;
  localparam int MD = 2;
  localparam int RW = 32;
  localparam int DW = NK * BW;

  logic clk = 1'b0;
  logic rst, i_start, i_conf_sat, i_psum_vld, i_mem_rvld;
  logic [RW-1:0] i_conf_seglen, i_conf_npass, i_conf_ngroup;
  logic [AW-1:0] i_conf_stride, o_mem_radd, o_mem_wadd;
  logic [DW-1:0] i_psum_dat, i_mem_rdat, o_mem_wdat;
  logic o_mem_rden, o_mem_wren, o_busy, o_done, o_ovf, o_err;

  always #5 clk = ~clk;

  psum_accum_ctrl_gen #(.BIT_WIDTH(BW), .NUM_KERNEL(NK), .ADDR_WIDTH(AW), .MEM_DELAY(MD), .REG_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_conf_seglen(i_conf_seglen), .i_conf_npass(i_conf_npass), .i_conf_ngroup(i_conf_ngroup),
    .i_conf_stride(i_conf_stride), .i_conf_sat(i_conf_sat),
    .i_psum_vld(i_psum_vld), .i_psum_dat(i_psum_dat),
    .o_mem_radd(o_mem_radd), .o_mem_rden(o_mem_rden), .i_mem_rdat(i_mem_rdat), .i_mem_rvld(i_mem_rvld),
    .o_mem_wadd(o_mem_wadd), .o_mem_wren(o_mem_wren), .o_mem_wdat(o_mem_wdat),
    .o_busy(o_busy), .o_done(o_done), .o_ovf(o_ovf), .o_err(o_err)
  );

  typedef struct {int due; logic [DW-1:0] d; bit drop;} rsp_t;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_n = 0;
  int rd_drop_idx = -1;
  int done_cyc = -1;
  bit exp_ovf = 0;
  bit exp_err = 0;
  bit m_ovf;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ref_mem [0:255];
  rsp_t rsp_q[$];
  logic [AW-1:0] wr_a[$];
  logic [DW-1:0] wr_d[$];
  int wr_c[$];
  int acc_c[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory model: responds MD cycles after a read; writes land while wren is seen.
  task automatic tick();
    rsp_t r;
    i_mem_rvld = 1'b0;
    i_mem_rdat = '0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      if (!r.drop) begin
        i_mem_rvld = 1'b1;
        i_mem_rdat = r.d;
      end
    end
    #1;
    if (o_mem_wren) begin
      mem[o_mem_wadd[7:0]] = o_mem_wdat;
      wr_a.push_back(o_mem_wadd);
      wr_d.push_back(o_mem_wdat);
      wr_c.push_back(cyc);
    end
    if (o_mem_rden) begin
      r.due  = cyc + MD;
      r.d    = mem[o_mem_radd[7:0]];
      r.drop = (rd_n == rd_drop_idx);
      rsp_q.push_back(r);
      rd_n++;
    end
    if (o_done && done_cyc < 0) done_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [DW-1:0] model_add(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sat);
    logic [DW-1:0] r;
    int s;
    r = '0;
    for (int k = 0; k < NK; k++) begin
      s = int'($signed(a[k*BW +: BW])) + int'($signed(b[k*BW +: BW]));
      if (s > 127 || s < -128) begin
        m_ovf = 1;
        if (sat) s = (s > 127) ? 127 : -128;
      end
      r[k*BW +: BW] = s[7:0];
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rsp_q.delete();
    exp_ovf = 0;
    exp_err = 0;
  endtask

  task automatic clear_log();
    wr_a.delete(); wr_d.delete(); wr_c.delete(); acc_c.delete();
    rd_n = 0;
    done_cyc = -1;
  endtask

  task automatic feed(input logic [DW-1:0] ps);
    i_psum_vld = 1'b1;
    i_psum_dat = ps;
    tick();
    i_psum_vld = 1'b0;
  endtask

  task automatic run_job(input string tag, input int L, input int P, input int G, input int stride,
                         input bit sat, input bit use_pat, input logic [DW-1:0] pat0,
                         input logic [DW-1:0] pat1, input int drop_idx);
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    logic [DW-1:0] ps;
    int nrd, a, t, lat_bad;
    rd_drop_idx = -1;
    i_conf_seglen = L; i_conf_npass = P; i_conf_ngroup = G; i_conf_stride = AW'(stride); i_conf_sat = sat;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    clear_log();
    rd_drop_idx = drop_idx;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    nrd = 0;
    for (int g = 0; g <= G; g++)
      for (int p = 0; p <= P; p++)
        for (int i = 0; i <= L; i++) begin
          ps = use_pat ? ((p == 0) ? pat0 : pat1) : DW'($urandom());
          a = (g * stride + i) & 255;
          if (!use_pat) while ($urandom_range(0, 99) < 25) tick();
          if (p == 0) begin
            ref_mem[a] = ps;
            ea.push_back(AW'(a)); ed.push_back(ps); acc_c.push_back(cyc);
          end else begin
            if (nrd == drop_idx) exp_err = 1;
            else begin
              m_ovf = 0;
              ref_mem[a] = model_add(ref_mem[a], ps, sat);
              exp_ovf |= m_ovf;
              ea.push_back(AW'(a)); ed.push_back(ref_mem[a]); acc_c.push_back(cyc);
            end
            nrd++;
          end
          feed(ps);
        end
    t = 0;
    while (done_cyc < 0 && t < 100) begin tick(); t++; end
    chk({tag, "_done"}, done_cyc >= 0, 1);
    tick();
    chk({tag, "_nwr"}, wr_a.size(), ea.size());
    lat_bad = 0;
    for (int i = 0; i < ea.size() && i < wr_a.size(); i++) begin
      chk({tag, "_wadd"}, wr_a[i], ea[i]);
      chk({tag, "_wdat"}, wr_d[i], ed[i]);
      if (wr_c[i] - acc_c[i] != MD + 1) lat_bad++;
    end
    chk({tag, "_lat"}, lat_bad, 0);
    chk({tag, "_done_t"}, done_cyc, (wr_c.size() > 0) ? wr_c[wr_c.size()-1] + 1 : -2);
    chk({tag, "_nrd"}, rd_n, P * (L + 1) * (G + 1));
    chk({tag, "_ovf"}, o_ovf, exp_ovf);
    chk({tag, "_err"}, o_err, exp_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int L, P, G, S;
    rst = 1'b1; i_start = 0; i_conf_sat = 0; i_psum_vld = 0; i_mem_rvld = 0;
    i_conf_seglen = 0; i_conf_npass = 0; i_conf_ngroup = 0; i_conf_stride = 0;
    i_psum_dat = 0; i_mem_rdat = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    @(negedge clk);
    do_reset();
    #1;
    chk("reset_outs", {o_mem_rden, o_mem_wren, o_busy, o_done, o_ovf, o_err, o_mem_wadd, o_mem_radd}, 0);
    chk("reset_wdat", o_mem_wdat, 0);

    run_job("basic", 3, 1, 0, 4, 1'b0, 1'b1, 32'h04030201, 32'h04030201, -1);
    chk("basic_w0", (wr_d.size() == 8) ? wr_d[0] : 'x, 32'h04030201);
    chk("basic_w4", (wr_d.size() == 8) ? wr_d[4] : 'x, 32'h08060402);

    run_job("sat", 3, 1, 0, 4, 1'b1, 1'b1, 32'h80807070, 32'hFFFF2020, -1);
    chk("sat_word", (wr_d.size() == 8) ? wr_d[7] : 'x, 32'h80807F7F);
    do_reset();
    run_job("wrap", 3, 1, 0, 4, 1'b0, 1'b1, 32'h80807070, 32'hFFFF2020, -1);
    chk("wrap_word", (wr_d.size() == 8) ? wr_d[7] : 'x, 32'h7F7F9090);
    do_reset();

    run_job("groups", 3, 0, 2, 16, 1'b0, 1'b0, '0, '0, -1);
    chk("groups_a8", (wr_a.size() == 12) ? wr_a[8] : 'x, 32);

    for (int n = 0; n < 3; n++) begin
      L = $urandom_range(3, 6); P = $urandom_range(0, 2); G = $urandom_range(0, 2);
      S = $urandom_range(L + 1, 40);
      run_job("rand", L, P, G, S, 1'($urandom_range(0, 1)), 1'b0, '0, '0, -1);
    end

    // Abort a job with two pass-1 reads still in flight.
    i_conf_seglen = 3; i_conf_npass = 1; i_conf_ngroup = 0; i_conf_stride = 4; i_conf_sat = 0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int i = 0; i < 6; i++) feed(DW'($urandom()));
    chk("restart_busy", o_busy, 1);
    run_job("restart", 3, 1, 0, 4, 1'b0, 1'b0, '0, '0, -1);
    chk("restart_a0", (wr_a.size() > 0) ? wr_a[0] : 'x, 0);

    run_job("proto", 3, 1, 0, 4, 1'b0, 1'b0, '0, '0, 1);

    // Reset while draining.
    i_conf_seglen = 3; i_conf_npass = 0; i_conf_ngroup = 0; i_conf_stride = 4;
    i_start = 1'b1; tick(); i_start = 1'b0;
    for (int i = 0; i < 4; i++) feed(DW'($urandom()));
    chk("drain_busy", o_busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    rsp_q.delete(); exp_ovf = 0; exp_err = 0;
    clear_log();
    #1;
    chk("rstdrain_outs", {o_mem_rden, o_mem_wren, o_busy, o_done, o_ovf, o_err, o_mem_wadd, o_mem_radd}, 0);
    chk("rstdrain_wdat", o_mem_wdat, 0);
    for (int i = 0; i < 5; i++) tick();
    chk("rstdrain_nwr", wr_a.size(), 0);

    // Invalid config from IDLE.
    i_conf_seglen = 1; i_conf_npass = 1; i_conf_ngroup = 0;
    i_start = 1'b1; tick(); i_start = 1'b0;
    clear_log();
    #1;
    chk("cfg_err", o_err, 1);
    chk("cfg_idle", {o_busy, o_done}, 0);
    for (int i = 0; i < 4; i++) feed(DW'($urandom()));
    for (int i = 0; i < 5; i++) tick();
    chk("cfg_nrd", rd_n, 0);
    chk("cfg_nwr", wr_a.size(), 0);
    chk("cfg_still_idle", o_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/psum_accum_ctrl_gen.md
Name: psum_accum_ctrl_gen

Overview:
Parametrised partial-sum accumulator controller. Each cycle it accepts one packed vector of NUM_KERNEL partial sums and performs a read-modify-write against a scratch memory with configurable read latency. Over a configurable number of passes per output group, the first pass writes the psum directly and later passes add to the stored value, with optional saturation. It sits between the PE-array psum outputs and the psum BRAM controller, and reports done, overflow and error status.

Parameters:
BIT_WIDTH, 8, width of one signed psum lane
NUM_KERNEL, 4, lanes per vector; memory word = NUM_KERNEL*BIT_WIDTH
ADDR_WIDTH, 16, memory address width
MEM_DELAY, 2, cycles from o_mem_rden to i_mem_rvld (>=1)
REG_WIDTH, 32, config register width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_start  in  1  pulse: load config, clear counters, enter ACCUM
i_conf_seglen  in  REG_WIDTH  psums per pass minus 1 (L)
i_conf_npass  in  REG_WIDTH  passes per group minus 1 (P)
i_conf_ngroup  in  REG_WIDTH  groups minus 1 (G)
i_conf_stride  in  ADDR_WIDTH  base-address increment per group
i_conf_sat  in  1  1 = saturate lanes, 0 = wrap
i_psum_vld  in  1  psum vector valid
i_psum_dat  in  NUM_KERNEL*BIT_WIDTH  lane k at [k*BIT_WIDTH +: BIT_WIDTH]
o_mem_radd  out  ADDR_WIDTH  read address
o_mem_rden  out  1  read enable
i_mem_rdat  in  NUM_KERNEL*BIT_WIDTH  read data
i_mem_rvld  in  1  read data valid
o_mem_wadd  out  ADDR_WIDTH  write address
o_mem_wren  out  1  write enable
o_mem_wdat  out  NUM_KERNEL*BIT_WIDTH  write data
o_busy  out  1  in ACCUM or DRAIN
o_done  out  1  level; held in DONE
o_ovf  out  1  sticky: any lane signed overflow
o_err  out  1  sticky: config or protocol error

Behaviour:
- Reset: all outputs 0; state IDLE; counters, base, sticky flags cleared. Reset mid-operation aborts; no further writes are issued.
- States:
  - IDLE -> ACCUM on i_start with valid config.
  - ACCUM -> DRAIN after the last psum (group G, pass P, index L) is accepted.
  - DRAIN -> DONE when the pipeline is empty.
  - DONE -> ACCUM on i_start.
- Config check on i_start: L < MEM_DELAY+1 is invalid (read-after-write hazard). An invalid config sets o_err and leaves the state unchanged.
- i_start in ACCUM/DRAIN: restart. In-flight pipeline entries are squashed (no write); o_ovf and o_err are kept; counters are cleared.
- Config inputs are sampled only on an accepted i_start.
- psum acceptance: i_psum_vld in ACCUM only; ignored in other states.
- Addressing: addr = base + idx. idx 0..L increments per accepted psum. idx wraps to 0 and pass++ after L. pass wraps to 0 after P, then group++ and base += stride (mod 2^ADDR_WIDTH).
- Read issue: o_mem_rden = accepted & pass!=0, combinational, same cycle. o_mem_radd = addr. Pass 0 issues no read.
- Shadow pipeline, MEM_DELAY deep: carries vld, first flag, addr, psum.
- Entry reaching stage MEM_DELAY at cycle T+MEM_DELAY:
  - first=1: wdat = psum.
  - first=0: requires i_mem_rvld. wdat = rdat + psum per lane, signed.
  - Missing rvld: o_err set and the write is dropped.
  - i_mem_rvld with no expecting entry: o_err set.
- Write: registered. o_mem_wren/wadd/wdat valid at T+MEM_DELAY+1; one write per accepted psum.
- Arithmetic: a lane overflows when both operands share a sign and the sum's sign differs.
  - Overflow sets o_ovf in both modes.
  - sat=1 clamps the lane to 2^(B-1)-1 or -2^(B-1); sat=0 wraps.
- o_done rises the cycle after the last write; cleared on i_start or rst.

Test Plan:
- Basic: B=8, N=4, MEM_DELAY=2, L=3, P=1, G=0, stride=4. Pass0 psums {1,2,3,4}×4 addr 0..3, pass1 same with memory model returning pass0 data -> pass0 writes {1,2,3,4} with wren at T+3; pass1 writes {2,4,6,8}; o_done one cycle after last write; exactly 8 writes.
- Saturation: stored lane 0x70, psum 0x20. sat=1 -> 0x7F, o_ovf=1. sat=0 -> 0x90, o_ovf=1. Stored 0x80 + psum 0xFF with sat=1 -> 0x80.
- Groups/addressing: L=3, P=0, G=2, stride=16 -> write addresses 0-3, 16-19, 32-35; no reads issued; done after 12 writes.
- Config error: L=1 with MEM_DELAY=2 -> o_err=1, state stays IDLE, no reads or writes.
- Protocol error: suppress i_mem_rvld for one pass-1 read -> that write dropped, o_err=1; other writes correct.
- Restart/reset: i_start mid-ACCUM with 2 reads in flight -> those writes squashed, addresses restart at 0. rst mid-DRAIN -> all outputs 0 next cycle.
